// File: rtl/adc_sar_logic.sv
// SAR ADC controller: sample phase, binary-search bit trials on the capacitive DAC,
// and a registered result word with a one-cycle finish pulse.
module adc_sar_logic #(
    parameter int RESOLUTION   = 12,
    parameter int SAMPLE_CNT_W = 4
) (
    input  logic                    clk_dig_in,
    input  logic                    rst_in,
    input  logic                    en_in,
    input  logic                    comp_result_in,
    input  logic [SAMPLE_CNT_W-1:0] sample_cycles_in,
    output logic                    sample_p_out,
    output logic                    sample_n_out,
    output logic                    nsample_p_out,
    output logic                    nsample_n_out,
    output logic [RESOLUTION-1:0]   dac_p_out,
    output logic [RESOLUTION-1:0]   dac_n_out,
    output logic [RESOLUTION-1:0]   result_out,
    output logic                    conv_finished_out,
    output logic                    busy_out
);

    localparam int IDX_W = $clog2(RESOLUTION);
    localparam logic [RESOLUTION-1:0] MSB_CODE = {1'b1, {(RESOLUTION-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONV,
        DONE
    } state_t;

    state_t                  state;
    logic [SAMPLE_CNT_W-1:0] sample_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [RESOLUTION-1:0]   code;
    logic [RESOLUTION-1:0]   resolved;
    logic [RESOLUTION-1:0]   next_trial;

    // NOTE: every always_comb output is given a full default first so no latch is inferred.
    always_comb begin
        resolved           = code;
        resolved[bit_idx]  = comp_result_in;
        next_trial         = resolved;
        if (bit_idx != '0) begin
            next_trial[bit_idx - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk_dig_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= IDLE;
            sample_cnt        <= '0;
            bit_idx           <= '0;
            code              <= '0;
            sample_p_out      <= 1'b1;
            sample_n_out      <= 1'b1;
            nsample_p_out     <= 1'b0;
            nsample_n_out     <= 1'b0;
            dac_p_out         <= '0;
            dac_n_out         <= '0;
            result_out        <= '0;
            conv_finished_out <= 1'b0;
            busy_out          <= 1'b0;
        end else begin
            conv_finished_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_in) begin
                        state      <= SAMPLE;
                        busy_out   <= 1'b1;
                        sample_cnt <= sample_cycles_in;
                    end
                end

                SAMPLE: begin
                    if (!en_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else if (sample_cnt != '0) begin
                        sample_cnt <= sample_cnt - 1'b1;
                    end else begin
                        state         <= CONV;
                        sample_p_out  <= 1'b0;
                        sample_n_out  <= 1'b0;
                        nsample_p_out <= 1'b1;
                        nsample_n_out <= 1'b1;
                        code          <= MSB_CODE;
                        dac_p_out     <= MSB_CODE;
                        dac_n_out     <= ~MSB_CODE;
                        bit_idx       <= IDX_W'(RESOLUTION - 1);
                    end
                end

                CONV: begin
                    // Abort wins even on the final trial edge: no result, no pulse.
                    if (!en_in) begin
                        state         <= IDLE;
                        busy_out      <= 1'b0;
                        sample_p_out  <= 1'b1;
                        sample_n_out  <= 1'b1;
                        nsample_p_out <= 1'b0;
                        nsample_n_out <= 1'b0;
                        dac_p_out     <= '0;
                        dac_n_out     <= '0;
                    end else begin
                        code      <= next_trial;
                        dac_p_out <= next_trial;
                        dac_n_out <= ~next_trial;
                        if (bit_idx == '0) begin
                            state             <= DONE;
                            result_out        <= resolved;
                            conv_finished_out <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end
                end

                DONE: begin
                    sample_p_out  <= 1'b1;
                    sample_n_out  <= 1'b1;
                    nsample_p_out <= 1'b0;
                    nsample_n_out <= 1'b0;
                    dac_p_out     <= '0;
                    dac_n_out     <= '0;
                    if (en_in) begin
                        state      <= SAMPLE;
                        sample_cnt <= sample_cycles_in;
                    end else begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sar_logic.sv
// Scoreboard bench for adc_sar_logic: a behavioural comparator drives the trials, expected
// results and pulse edges are queued at stimulus time and checked when the pulse appears.
module tb_adc_sar_logic;

    localparam int RES = 12;
    localparam int SCW = 4;

    logic           clk_dig_in = 1'b0;
    logic           rst_in;
    logic           en_in;
    logic           comp_result_in;
    logic [SCW-1:0] sample_cycles_in;
    logic           sample_p_out, sample_n_out, nsample_p_out, nsample_n_out;
    logic [RES-1:0] dac_p_out, dac_n_out, result_out;
    logic           conv_finished_out, busy_out;

    logic [RES-1:0] vin;
    int             edge_cnt = 0;
    int             checks   = 0;
    int             failures = 0;

    typedef struct {
        logic [RES-1:0] res;
        int             edge_no;
    } exp_t;
    exp_t exp_q[$];

    adc_sar_logic #(.RESOLUTION(RES), .SAMPLE_CNT_W(SCW)) dut (
        .clk_dig_in        (clk_dig_in),
        .rst_in            (rst_in),
        .en_in             (en_in),
        .comp_result_in    (comp_result_in),
        .sample_cycles_in  (sample_cycles_in),
        .sample_p_out      (sample_p_out),
        .sample_n_out      (sample_n_out),
        .nsample_p_out     (nsample_p_out),
        .nsample_n_out     (nsample_n_out),
        .dac_p_out         (dac_p_out),
        .dac_n_out         (dac_n_out),
        .result_out        (result_out),
        .conv_finished_out (conv_finished_out),
        .busy_out          (busy_out)
    );

    always #5 clk_dig_in = ~clk_dig_in;
    always @(posedge clk_dig_in) edge_cnt <= edge_cnt + 1;

    // Ideal comparator: input at or above the trial code keeps the bit.
    assign comp_result_in = (vin >= dac_p_out);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_dig_in);
    endtask

    // Queue the expected result; the pulse shows up after edge sc+RES+2 counted from the next edge.
    task automatic expect_conv(input logic [RES-1:0] v, input logic [SCW-1:0] sc, input int offset);
        exp_t e;
        e.res     = v;
        e.edge_no = edge_cnt + int'(sc) + RES + 2 + offset;
        exp_q.push_back(e);
    endtask

    task automatic wait_pulse();
        int n = 0;
        while (!conv_finished_out && n < 64) begin
            step(1);
            n++;
        end
        if (!conv_finished_out) check("pulse_timeout", {31'b0, conv_finished_out}, 1);
    endtask

    task automatic check_parked(input string tag);
        check({tag, "_busy"},    {31'b0, busy_out}, 0);
        check({tag, "_sample"},  {30'b0, sample_p_out, sample_n_out}, 32'h3);
        check({tag, "_nsample"}, {30'b0, nsample_p_out, nsample_n_out}, 0);
        check({tag, "_dac_p"},   {20'b0, dac_p_out}, 0);
        check({tag, "_dac_n"},   {20'b0, dac_n_out}, 0);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each finish pulse.
    always @(negedge clk_dig_in) begin
        if (!rst_in) begin
            check("nsample_p_inv", {31'b0, nsample_p_out}, {31'b0, ~sample_p_out});
            check("nsample_n_inv", {31'b0, nsample_n_out}, {31'b0, ~sample_n_out});
            if (!sample_p_out)
                check("dac_n_inv", {20'b0, dac_n_out}, {20'b0, ~dac_p_out});
            if (conv_finished_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {31'b0, conv_finished_out}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", {20'b0, result_out}, {20'b0, e.res});
                    check("pulse_edge", edge_cnt, e.edge_no);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RES-1:0] full;
        rst_in           = 1'b1;
        en_in            = 1'b0;
        vin              = '0;
        sample_cycles_in = 4'd3;
        step(2);
        check_parked("por");
        check("por_result", {20'b0, result_out}, 0);
        check("por_pulse", {31'b0, conv_finished_out}, 0);
        rst_in = 1'b0;

        // Reset mid-conversion: everything returns to reset values immediately.
        vin   = 12'h3C3;
        en_in = 1'b1;
        step(8);
        check("midconv_busy", {31'b0, busy_out}, 1);
        check("midconv_sample", {31'b0, sample_p_out}, 0);
        #1 rst_in = 1'b1;
        #1;
        check_parked("rst_async");
        check("rst_async_result", {20'b0, result_out}, 0);
        check("rst_async_pulse", {31'b0, conv_finished_out}, 0);
        step(1);
        rst_in = 1'b0;
        en_in  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_parked("idle_hold");
        end

        // Single conversion, sample_cycles_in = 3.
        expect_conv(12'hA5C, 4'd3, 0);
        vin   = 12'hA5C;
        en_in = 1'b1;
        wait_pulse();
        en_in = 1'b0;
        step(1);
        check("single_pulse_fall", {31'b0, conv_finished_out}, 0);
        check_parked("single_after");
        check("single_hold", {20'b0, result_out}, 32'hA5C);

        // Lowest code.
        expect_conv(12'h000, 4'd3, 0);
        vin   = 12'h000;
        en_in = 1'b1;
        wait_pulse();
        en_in = 1'b0;
        step(1);

        // Highest code, trial codes fill in from the MSB.
        expect_conv(12'hFFF, 4'd3, 0);
        vin   = 12'hFFF;
        en_in = 1'b1;
        step(5);
        for (int k = 0; k < RES; k++) begin
            full = 12'hFFF;
            check("trial_ffff", {20'b0, dac_p_out}, {20'b0, full << (RES - 1 - k)});
            step(1);
        end
        wait_pulse();
        en_in = 1'b0;
        step(1);

        // Back-to-back: second pulse 17 edges after the first.
        expect_conv(12'h123, 4'd3, 0);
        expect_conv(12'h7FF, 4'd3, 17);
        vin   = 12'h123;
        en_in = 1'b1;
        wait_pulse();
        vin = 12'h7FF;
        step(1);
        check("b2b_reopen", {31'b0, sample_p_out}, 1);
        check("b2b_busy", {31'b0, busy_out}, 1);
        check("b2b_dac", {20'b0, dac_p_out}, 0);
        wait_pulse();
        en_in = 1'b0;
        step(1);
        check("b2b_reopen2", {31'b0, sample_p_out}, 1);

        // Abort at the 5th CONV edge.
        vin   = 12'h456;
        en_in = 1'b1;
        step(9);
        check("abort_pre_busy", {31'b0, busy_out}, 1);
        check("abort_pre_conv", {31'b0, sample_p_out}, 0);
        en_in = 1'b0;
        step(1);
        check_parked("abort");
        step(3);
        check("abort_result_kept", {20'b0, result_out}, 32'h7FF);
        expect_conv(12'h456, 4'd3, 0);
        en_in = 1'b1;
        wait_pulse();
        en_in = 1'b0;
        step(1);

        // Minimum sample phase.
        expect_conv(12'h555, 4'd0, 0);
        vin              = 12'h555;
        sample_cycles_in = 4'd0;
        en_in            = 1'b1;
        wait_pulse();
        en_in = 1'b0;
        step(3);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
